// File: rtl/vx_operands_dispatch_buf.sv
// vx_operands_dispatch_buf
//   Consumer end of the operands handshake. Each accepted bundle is steered by
//   its ex_type into one of NUM_EX independent 2-entry elastic FIFOs. Each FIFO
//   feeds one execution unit, so backpressure from one unit never blocks the
//   other lanes. Cycles where the collector offers a bundle that cannot be
//   taken are counted.
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   in_valid     bundle offered by the operand collector
//   in_data      flattened operands bundle (passed through unmodified)
//   in_ex_type   lane select
//   in_ready     bundle taken when in_valid && in_ready (depends only on the
//                selected lane's fill level, never on out_ready)
//   out_valid    per-lane head valid
//   out_data     per-lane head bundle, lane i at [i*DATA_W +: DATA_W]
//   out_ready    per-lane consumer ready; lane i pops on out_valid[i] && out_ready[i]
//   stall_cnt    free-running count of cycles with in_valid && !in_ready (wraps)
//   bad_ex       sticky flag: a bundle with ex_type >= NUM_EX was accepted and dropped
module vx_operands_dispatch_buf #(
  parameter int NUM_EX  = 4,
  parameter int EX_BITS = 2,
  parameter int DATA_W  = 512,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [EX_BITS-1:0]       in_ex_type,
  output logic                     in_ready,
  output logic [NUM_EX-1:0]        out_valid,
  output logic [NUM_EX*DATA_W-1:0] out_data,
  input  logic [NUM_EX-1:0]        out_ready,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     bad_ex
);

  localparam int SEL_N = 1 << EX_BITS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_t;

  logic [NUM_EX-1:0] full;
  // Both vectors cover every encodable ex_type so they can be indexed directly
  // by in_ex_type; selects with no lane read as "not full" and "no lane".
  logic [SEL_N-1:0]  full_sel;
  logic [SEL_N-1:0]  lane_exists;
  logic              accept;
  logic              sel_bad;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_sel
      if (gi < NUM_EX) begin : g_real
        assign full_sel[gi]    = full[gi];
        assign lane_exists[gi] = 1'b1;
      end else begin : g_none
        assign full_sel[gi]    = 1'b0;
        assign lane_exists[gi] = 1'b0;
      end
    end
  endgenerate

  // A full lane is not ready even if it pops this cycle: keeps out_ready off
  // the in_ready path.
  assign in_ready = !full_sel[in_ex_type];
  assign accept   = in_valid && in_ready;
  assign sel_bad  = !lane_exists[in_ex_type];

  generate
    for (gi = 0; gi < NUM_EX; gi++) begin : g_lane
      lane_state_t       state;
      lane_state_t       state_next;
      logic [DATA_W-1:0] head;
      logic [DATA_W-1:0] head_next;
      logic [DATA_W-1:0] tail;
      logic [DATA_W-1:0] tail_next;
      logic              push;
      logic              pop;

      assign push = accept && (in_ex_type == EX_BITS'(gi));
      assign pop  = out_valid[gi] && out_ready[gi];

      // head is always the oldest entry; tail holds the second entry in FULL.
      always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        unique case (state)
          EMPTY: begin
            if (push) begin
              state_next = ONE;
              head_next  = in_data;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_next = in_data;
            end else if (push) begin
              state_next = FULL;
              tail_next  = in_data;
            end else if (pop) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              state_next = ONE;
              head_next  = tail;
            end
          end
          default: state_next = EMPTY;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= EMPTY;
        end else begin
          state <= state_next;
        end
      end

      // Payload needs no reset: it is only observed while the lane is non-empty.
      always_ff @(posedge clk) begin
        head <= head_next;
        tail <= tail_next;
      end

      assign out_valid[gi]                   = (state != EMPTY);
      assign full[gi]                        = (state == FULL);
      assign out_data[gi*DATA_W +: DATA_W]   = head;

`ifndef SYNTHESIS
      a_out_hold: assert property (@(posedge clk) disable iff (reset)
        out_valid[gi] && !out_ready[gi] |=>
          out_valid[gi] && $stable(out_data[gi*DATA_W +: DATA_W]));
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      bad_ex    <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (accept && sel_bad) begin
        bad_ex <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A stalled bundle may be withdrawn, but if still offered it must be unchanged.
  a_in_stable: assert property (@(posedge clk) disable iff (reset)
    in_valid && !in_ready |=>
      !in_valid || ($stable(in_data) && $stable(in_ex_type)));
`endif

endmodule
